pipelined_ripple_adder: RTL and testbench

//   Parametrised, pipelined successor of the combinational ripple-carry adder.

---
 rtl/adder_pkg.sv | 22 ++
 rtl/adder_slice.sv | 27 ++
 rtl/pipelined_ripple_adder.sv | 124 ++++++++++++
 tb/tb_pipelined_ripple_adder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared slicing helpers and stage control record for the pipelined ripple adder.
package adder_pkg;

  typedef struct packed {
    logic vld;
    logic carry;
  } stage_ctl_t;

  // Bounds of the bit range rippled by stage k; hi < lo marks an empty slice.
  function automatic int slice_lo(input int k, input int slice, input int width);
    int lo;
    lo = k * slice;
    return (lo < width) ? lo : width;
  endfunction

  function automatic int slice_hi(input int k, input int slice, input int width);
    int top;
    top = (k + 1) * slice;
    return ((top < width) ? top : width) - 1;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational ripple-carry slice: SW full-adder cells chained from cin to cout.
module adder_slice
  import adder_pkg::*;
#(
  parameter int SW = 1
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] s,
  output logic          cout
);

  logic [SW:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SW; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[SW];
  end

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder with a global valid/ready stall.
// Define ADDER_OVF_EN to add the registered signed-overflow output Ovf.
module pipelined_ripple_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef ADDER_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int SLICE = (WIDTH + STAGES - 1) / STAGES;

  logic             adv;
  logic [WIDTH-1:0] a_src   [STAGES];
  logic [WIDTH-1:0] b_src   [STAGES];
  logic [WIDTH-1:0] sum_src [STAGES];
  stage_ctl_t       ctl_src [STAGES];
  logic [WIDTH-1:0] sum_nxt [STAGES];
  stage_ctl_t       ctl_nxt [STAGES];
  logic [WIDTH-1:0] a_p     [STAGES];
  logic [WIDTH-1:0] b_p     [STAGES];
  logic [WIDTH-1:0] sum_p   [STAGES];
  stage_ctl_t       ctl_p   [STAGES];

  // Whole pipe advances together; a held output freezes every stage.
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LO = slice_lo(k, SLICE, WIDTH);
    localparam int HI = slice_hi(k, SLICE, WIDTH);

    if (k == 0) begin : g_src
      assign a_src[k]   = A;
      assign b_src[k]   = B;
      assign sum_src[k] = '0;
      assign ctl_src[k] = '{vld: in_valid, carry: Cin};
    end else begin : g_src
      assign a_src[k]   = a_p[k-1];
      assign b_src[k]   = b_p[k-1];
      assign sum_src[k] = sum_p[k-1];
      assign ctl_src[k] = ctl_p[k-1];
    end

    if (HI >= LO) begin : g_add
      logic [HI-LO:0]   s_slice;
      logic             c_slice;
      logic [WIDTH-1:0] merged;

      adder_slice #(.SW(HI - LO + 1)) u_slice (
        .a    (a_src[k][HI:LO]),
        .b    (b_src[k][HI:LO]),
        .cin  (ctl_src[k].carry),
        .s    (s_slice),
        .cout (c_slice)
      );

      always_comb begin
        merged        = sum_src[k];
        merged[HI:LO] = s_slice;
      end

      assign sum_nxt[k] = merged;
      assign ctl_nxt[k] = '{vld: ctl_src[k].vld, carry: c_slice};
    end else begin : g_fwd
      // Empty trailing slice: nothing left to add, just carry the word along.
      assign sum_nxt[k] = sum_src[k];
      assign ctl_nxt[k] = ctl_src[k];
    end

    // ---- stage k register boundary ----
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_p[k]   <= '0;
        b_p[k]   <= '0;
        sum_p[k] <= '0;
        ctl_p[k] <= '0;
      end else if (adv) begin
        a_p[k]   <= a_src[k];
        b_p[k]   <= b_src[k];
        sum_p[k] <= sum_nxt[k];
        ctl_p[k] <= ctl_nxt[k];
      end
    end

`ifdef ADDER_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_p;

      // The final sum is complete here, so overflow is registered alongside it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_p <= 1'b0;
        end else if (adv) begin
          ovf_p <= (a_src[k][WIDTH-1] == b_src[k][WIDTH-1]) &
                   (sum_nxt[k][WIDTH-1] != a_src[k][WIDTH-1]);
        end
      end

      assign Ovf = ovf_p;
    end
`endif
  end

  assign S         = sum_p[STAGES-1];
  assign Cout      = ctl_p[STAGES-1].carry;
  assign out_valid = ctl_p[STAGES-1].vld;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Self-checking bench: 8-bit/2-stage adder against a result delay-line model, plus a 7-bit/3-stage instance.
module tb_pipelined_ripple_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       iv0, ir0, ov0, or0, c0, co0;
  logic [7:0] a0, b0, s0;
  logic       iv1, ir1, ov1, or1, c1, co1;
  logic [6:0] a1, b1, s1;
`ifdef ADDER_OVF_EN
  logic       ovf0, ovf1;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int acc_cnt, del_cnt;

  // Model: a STAGES-deep line of whole results {ovf, Cout, S} with their valid flags.
  logic       mv [2];
  logic [8:0] mr [2];
  logic       mo [2];

  pipelined_ripple_adder #(.WIDTH(8), .STAGES(2)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .A(a0), .B(b0), .Cin(c0),
    .out_valid(ov0), .out_ready(or0), .S(s0), .Cout(co0)
`ifdef ADDER_OVF_EN
    , .Ovf(ovf0)
`endif
  );

  pipelined_ripple_adder #(.WIDTH(7), .STAGES(3)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1), .Cin(c1),
    .out_valid(ov1), .out_ready(or1), .S(s1), .Cout(co1)
`ifdef ADDER_OVF_EN
    , .Ovf(ovf1)
`endif
  );

  task automatic model_clear();
    mv[0] = 1'b0; mv[1] = 1'b0;
    mr[0] = '0;   mr[1] = '0;
    mo[0] = 1'b0; mo[1] = 1'b0;
  endtask

  // One clock of dut0: drive at the falling edge, check against the model, advance the model.
  task automatic cyc(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic ordy, output logic obs_v, output logic [7:0] obs_s,
                     output logic obs_c);
    logic [8:0] r;
    logic       adv;
    @(negedge clk);
    iv0 = v; a0 = a; b0 = b; c0 = c; or0 = ordy;
    #1;
    obs_v = ov0; obs_s = s0; obs_c = co0;
    tests_run++;
    if (ov0 !== mv[1]) begin
      tests_failed++;
      $display("FAIL out_valid: got %b want %b at %0t", ov0, mv[1], $time);
    end
    tests_run++;
    if (ir0 !== (!mv[1] | ordy)) begin
      tests_failed++;
      $display("FAIL in_ready: got %b want %b at %0t", ir0, !mv[1] | ordy, $time);
    end
    if (mv[1]) begin
      tests_run++;
      if ({co0, s0} !== mr[1]) begin
        tests_failed++;
        $display("FAIL result: got Cout=%b S=%h want Cout=%b S=%h at %0t",
                 co0, s0, mr[1][8], mr[1][7:0], $time);
      end
`ifdef ADDER_OVF_EN
      tests_run++;
      if (ovf0 !== mo[1]) begin
        tests_failed++;
        $display("FAIL ovf: got %b want %b at %0t", ovf0, mo[1], $time);
      end
`endif
    end
    if (ov0 && ordy) del_cnt++;
    r   = {1'b0, a} + {1'b0, b} + {8'd0, c};
    adv = !mv[1] | ordy;
    if (adv) begin
      if (v) acc_cnt++;
      mv[1] = mv[0]; mr[1] = mr[0]; mo[1] = mo[0];
      mv[0] = v;     mr[0] = r;     mo[0] = (a[7] == b[7]) && (r[7] != a[7]);
    end
  endtask

  task automatic test_reset();
    logic v; logic [7:0] s; logic c;
    rst = 1'b1;
    iv0 = 0; a0 = '0; b0 = '0; c0 = 0; or0 = 1;
    iv1 = 0; a1 = '0; b1 = '0; c1 = 0; or1 = 1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (ov0 !== 1'b0 || s0 !== 8'h00 || co0 !== 1'b0 || ir0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_idle: got v=%b S=%h C=%b rdy=%b want 0 00 0 1", ov0, s0, co0, ir0);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 8'h12, 8'h34, 1, 1, v, s, c);
    cyc(1, 8'hA5, 8'h5A, 1, 0, v, s, c);
    @(negedge clk);
    iv0 = 1; or0 = 0;
    #1;
    tests_run++;
    if (ov0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_inflight_pre: got out_valid=%b want 1", ov0);
    end
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if (ov0 !== 1'b0 || s0 !== 8'h00 || co0 !== 1'b0 || ir0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_async: got v=%b S=%h C=%b rdy=%b want 0 00 0 1", ov0, s0, co0, ir0);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; iv0 = 0; or0 = 1;
    model_clear();
  endtask

  task automatic test_directed();
    logic [7:0] da [6] = '{8'hFF, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'h00};
    logic [7:0] db [6] = '{8'h01, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00};
    logic       dc [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       dv [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [8:0] ex [4] = '{9'h100, 9'h01F, 9'h100, 9'h000};
    logic v; logic [7:0] s; logic c;
    for (int i = 0; i < 6; i++) begin
      cyc(dv[i], da[i], db[i], dc[i], 1, v, s, c);
      if (i >= 2) begin
        tests_run++;
        if (v !== 1'b1 || {c, s} !== ex[i-2]) begin
          tests_failed++;
          $display("FAIL directed_%0d: got v=%b Cout=%b S=%h want v=1 Cout=%b S=%h",
                   i - 2, v, c, s, ex[i-2][8], ex[i-2][7:0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic v; logic [7:0] s; logic c;
    for (int i = 0; i < 18; i++) begin
      cyc(i < 16, 8'($urandom), 8'($urandom), 1'($urandom), 1, v, s, c);
      if (i >= 2) begin
        tests_run++;
        if (v !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_gap_%0d: got out_valid=%b want 1", i, v);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic v; logic [7:0] s; logic c;
    logic [7:0] held_s; logic held_c;
    acc_cnt = 0; del_cnt = 0;
    for (int i = 0; i < 3; i++) cyc(1, 8'($urandom), 8'($urandom), 1'($urandom), 1, v, s, c);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'($urandom), 8'($urandom), 1'($urandom), 0, v, s, c);
      if (i == 0) begin
        held_s = s; held_c = c;
      end else begin
        tests_run++;
        if (s !== held_s || c !== held_c || ir0 !== 1'b0) begin
          tests_failed++;
          $display("FAIL bp_hold_%0d: got S=%h C=%b rdy=%b want S=%h C=%b rdy=0",
                   i, s, c, ir0, held_s, held_c);
        end
      end
    end
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 8'h00, 0, 1, v, s, c);
    tests_run++;
    if (del_cnt !== acc_cnt) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d results want %0d", del_cnt, acc_cnt);
    end
  endtask

  task automatic test_random();
    logic v; logic [7:0] s; logic c;
    acc_cnt = 0; del_cnt = 0;
    for (int i = 0; i < 150; i++)
      cyc(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
          $urandom_range(0, 3) != 0, v, s, c);
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 8'h00, 0, 1, v, s, c);
    tests_run++;
    if (del_cnt !== acc_cnt) begin
      tests_failed++;
      $display("FAIL random_count: got %0d results want %0d", del_cnt, acc_cnt);
    end
  endtask

  task automatic test_uneven();
    logic [6:0] ua [8];
    logic [6:0] ub [8];
    logic       uc [8];
    logic [7:0] ex [8];
    for (int i = 0; i < 8; i++) begin
      ua[i] = (i == 0) ? 7'h7F : 7'($urandom);
      ub[i] = (i == 0) ? 7'h7F : 7'($urandom);
      uc[i] = (i == 0) ? 1'b1  : 1'($urandom);
      ex[i] = {1'b0, ua[i]} + {1'b0, ub[i]} + {7'd0, uc[i]};
    end
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      iv1 = (j < 8); or1 = 1;
      a1 = (j < 8) ? ua[j] : 7'h00;
      b1 = (j < 8) ? ub[j] : 7'h00;
      c1 = (j < 8) ? uc[j] : 1'b0;
      #1;
      tests_run++;
      if (j >= 3 && j < 11) begin
        if (ov1 !== 1'b1 || {co1, s1} !== ex[j-3]) begin
          tests_failed++;
          $display("FAIL uneven_%0d: got v=%b Cout=%b S=%h want v=1 Cout=%b S=%h",
                   j - 3, ov1, co1, s1, ex[j-3][7], ex[j-3][6:0]);
        end
      end else if (ov1 !== 1'b0) begin
        tests_failed++;
        $display("FAIL uneven_idle_%0d: got out_valid=%b want 0", j, ov1);
      end
    end
    iv1 = 0;
  endtask

`ifdef ADDER_OVF_EN
  task automatic test_ovf();
    logic [7:0] oa [5] = '{8'h7F, 8'h80, 8'h10, 8'h00, 8'h00};
    logic [7:0] ob [5] = '{8'h01, 8'hFF, 8'h20, 8'h00, 8'h00};
    logic       eo [3] = '{1'b1, 1'b1, 1'b0};
    logic       ec [3] = '{1'b0, 1'b1, 1'b0};
    logic v; logic [7:0] s; logic c;
    for (int i = 0; i < 5; i++) begin
      cyc(i < 3, oa[i], ob[i], 0, 1, v, s, c);
      if (i >= 2) begin
        tests_run++;
        if (v !== 1'b1 || ovf0 !== eo[i-2] || c !== ec[i-2]) begin
          tests_failed++;
          $display("FAIL ovf_%0d: got v=%b Ovf=%b Cout=%b want v=1 Ovf=%b Cout=%b",
                   i - 2, v, ovf0, c, eo[i-2], ec[i-2]);
        end
      end
    end
  endtask
`endif

  initial begin
    acc_cnt = 0; del_cnt = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_uneven();
`ifdef ADDER_OVF_EN
    test_ovf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
